// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the 3x3 convolution load/compute sequencer.
package conv_pkg;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int K       = 3;
  localparam int N_KER   = 6;

  localparam int D_CNT   = IMG_W * IMG_H;
  localparam int W_CNT   = N_KER * K * K;
  localparam int OUT_DIM = IMG_W - K + 1;
  localparam int TAPS    = K * K;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Kernel / output-pixel / tap counter nest with combinational RAM read addresses.
// Counters sit at zero whenever run is low and advance one tap per cycle while it is high.
module conv_addr_gen
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [5:0] d_addr,
  output logic [5:0] w_addr,
  output logic       first_tap,
  output logic       last_tap,
  output logic       last_issue
);

  logic [2:0] k;
  logic [2:0] oy;
  logic [2:0] ox;
  logic [1:0] ky;
  logic [1:0] kx;

  logic kx_wrap;
  logic ky_wrap;
  logic ox_wrap;
  logic oy_wrap;
  logic k_wrap;

  logic [5:0] row;
  logic [5:0] col;

  // Each wrap strobe means every inner counter is also at its final value.
  assign kx_wrap = (kx == 2'(K - 1));
  assign ky_wrap = kx_wrap && (ky == 2'(K - 1));
  assign ox_wrap = ky_wrap && (ox == 3'(OUT_DIM - 1));
  assign oy_wrap = ox_wrap && (oy == 3'(OUT_DIM - 1));
  assign k_wrap  = oy_wrap && (k == 3'(N_KER - 1));

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      k  <= '0;
      oy <= '0;
      ox <= '0;
      ky <= '0;
      kx <= '0;
    end else begin
      kx <= kx_wrap ? 2'd0 : kx + 2'd1;
      if (kx_wrap) ky <= ky_wrap ? 2'd0 : ky + 2'd1;
      if (ky_wrap) ox <= ox_wrap ? 3'd0 : ox + 3'd1;
      if (ox_wrap) oy <= oy_wrap ? 3'd0 : oy + 3'd1;
      if (oy_wrap) k  <= k_wrap  ? 3'd0 : k  + 3'd1;
    end
  end

  assign row        = 6'(oy) + 6'(ky);
  assign col        = 6'(ox) + 6'(kx);
  assign d_addr     = (row * 6'(IMG_W)) + col;
  assign w_addr     = (6'(k) * 6'(TAPS)) + (6'(ky) * 6'(K)) + 6'(kx);
  assign first_tap  = (ky == 2'd0) && (kx == 2'd0);
  assign last_tap   = ky_wrap;
  assign last_issue = run && k_wrap;

endmodule

// File: rtl/conv_seq_ctrl.sv
// Load/compute sequencer: steers the serial load stream into the data and weight RAMs,
// then walks every kernel x output pixel x tap issuing read addresses and MAC framing.
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ram_en,
  input  logic          mode,
  input  logic [DW-1:0] din,
  output logic          d_we,
  output logic [5:0]    d_addr,
  output logic [DW-1:0] d_wdata,
  output logic          w_we,
  output logic [5:0]    w_addr,
  output logic [DW-1:0] w_wdata,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_last,
  output logic          busy,
  output logic          done,
  output logic          load_err
);

  state_t state, state_nx;

  logic [6:0] dcnt, dcnt_nx;
  logic [5:0] wcnt, wcnt_nx;
  logic       seen_w, seen_w_nx;
  logic       load_err_nx;
  logic [1:0] drain_cnt, drain_nx;
  logic       accept;

  logic       issue;
  logic [5:0] gen_d_addr;
  logic [5:0] gen_w_addr;
  logic       first_tap;
  logic       last_tap;
  logic       last_issue;

  logic [RD_LAT-1:0] en_q, clr_q, last_q;
  logic [RD_LAT:0]   en_ext, clr_ext, last_ext;

  assign issue = (state == S_CONV);

  conv_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .run        (issue),
    .d_addr     (gen_d_addr),
    .w_addr     (gen_w_addr),
    .first_tap  (first_tap),
    .last_tap   (last_tap),
    .last_issue (last_issue)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dcnt      <= '0;
      wcnt      <= '0;
      seen_w    <= 1'b0;
      load_err  <= 1'b0;
      drain_cnt <= '0;
      en_q      <= '0;
      clr_q     <= '0;
      last_q    <= '0;
    end else begin
      state     <= state_nx;
      dcnt      <= dcnt_nx;
      wcnt      <= wcnt_nx;
      seen_w    <= seen_w_nx;
      load_err  <= load_err_nx;
      drain_cnt <= drain_nx;
      en_q      <= en_ext[RD_LAT-1:0];
      clr_q     <= clr_ext[RD_LAT-1:0];
      last_q    <= last_ext[RD_LAT-1:0];
    end
  end

  // Byte acceptance is evaluated after the state case so it overrides the counter clears;
  // the first byte of a load is taken in IDLE where the counters are known to be zero.
  always_comb begin
    state_nx    = state;
    dcnt_nx     = dcnt;
    wcnt_nx     = wcnt;
    seen_w_nx   = seen_w;
    load_err_nx = load_err;
    drain_nx    = drain_cnt;
    d_we        = 1'b0;
    w_we        = 1'b0;
    accept      = ram_en && ((state == S_IDLE) || (state == S_LOAD));

    case (state)
      S_IDLE: begin
        dcnt_nx   = '0;
        wcnt_nx   = '0;
        seen_w_nx = 1'b0;
        drain_nx  = '0;
        if (ram_en) begin
          state_nx    = S_LOAD;
          load_err_nx = 1'b0;
        end
      end
      S_LOAD: begin
        if (!ram_en) begin
          dcnt_nx   = '0;
          wcnt_nx   = '0;
          seen_w_nx = 1'b0;
          if ((dcnt == 7'(D_CNT)) && (wcnt == 6'(W_CNT))) begin
            state_nx = S_CONV;
          end else begin
            state_nx    = S_IDLE;
            load_err_nx = 1'b1;
          end
        end
      end
      S_CONV: begin
        drain_nx = '0;
        if (last_issue) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == 2'(RD_LAT - 1)) state_nx = S_DONE;
        else drain_nx = drain_cnt + 2'd1;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (accept) begin
      if (!mode) begin
        if ((dcnt < 7'(D_CNT)) && !seen_w) begin
          d_we    = 1'b1;
          dcnt_nx = dcnt + 7'd1;
        end else begin
          load_err_nx = 1'b1;
        end
      end else begin
        seen_w_nx = 1'b1;
        if (wcnt < 6'(W_CNT)) begin
          w_we    = 1'b1;
          wcnt_nx = wcnt + 6'd1;
        end else begin
          load_err_nx = 1'b1;
        end
      end
    end
  end

  always_comb begin
    d_addr  = '0;
    w_addr  = '0;
    d_wdata = '0;
    w_wdata = '0;
    if (d_we) begin
      d_addr  = dcnt[5:0];
      d_wdata = din;
    end else if (issue) begin
      d_addr = gen_d_addr;
    end
    if (w_we) begin
      w_addr  = wcnt;
      w_wdata = din;
    end else if (issue) begin
      w_addr = gen_w_addr;
    end
  end

  // Issue-time flags enter at bit 0 and emerge RD_LAT cycles later, aligned to read data.
  assign en_ext   = {en_q,   issue};
  assign clr_ext  = {clr_q,  issue && first_tap};
  assign last_ext = {last_q, issue && last_tap};

  assign mac_en   = en_q[RD_LAT-1];
  assign mac_clr  = clr_q[RD_LAT-1];
  assign mac_last = last_q[RD_LAT-1];
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench: two sequencers (RD_LAT=1 and RD_LAT=2) share one randomized load stream
// and are checked against a tap-by-tap model of the load and convolution walk.
module tb_conv_seq_ctrl;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       ram_en = 1'b0;
  logic       mode   = 1'b0;
  logic [7:0] din    = '0;

  logic [1:0] d_we_o, w_we_o, mac_clr_o, mac_en_o, mac_last_o, busy_o, done_o, err_o;
  logic [5:0] d_addr_o  [2];
  logic [5:0] w_addr_o  [2];
  logic [7:0] d_wdata_o [2];
  logic [7:0] w_wdata_o [2];

  conv_seq_ctrl #(.DW(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .ram_en(ram_en), .mode(mode), .din(din),
    .d_we(d_we_o[0]), .d_addr(d_addr_o[0]), .d_wdata(d_wdata_o[0]),
    .w_we(w_we_o[0]), .w_addr(w_addr_o[0]), .w_wdata(w_wdata_o[0]),
    .mac_clr(mac_clr_o[0]), .mac_en(mac_en_o[0]), .mac_last(mac_last_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .load_err(err_o[0])
  );

  conv_seq_ctrl #(.DW(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .ram_en(ram_en), .mode(mode), .din(din),
    .d_we(d_we_o[1]), .d_addr(d_addr_o[1]), .d_wdata(d_wdata_o[1]),
    .w_we(w_we_o[1]), .w_addr(w_addr_o[1]), .w_wdata(w_wdata_o[1]),
    .mac_clr(mac_clr_o[1]), .mac_en(mac_en_o[1]), .mac_last(mac_last_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .load_err(err_o[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
    int f;
  } ev_t;

  ev_t dw_q  [2][$];
  ev_t ww_q  [2][$];
  ev_t tap_q [2][$];
  int  done_q[2][$];

  int hist_d [2][4];
  int hist_w [2][4];
  int n_clr  [2];
  int n_last [2];

  int n_checks = 0;
  int n_fail   = 0;

  int m_dcnt, m_wcnt, last_l;
  bit m_seen, m_err;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One load byte; the model decides whether it should be written and where.
  task automatic applyStimulus(input bit m, input logic [7:0] b);
    @(posedge clk);
    #1;
    ram_en = 1'b1;
    mode   = m;
    din    = b;
    if (!m) begin
      if (m_seen || m_dcnt == 64) m_err = 1'b1;
      else begin
        for (int u = 0; u < 2; u++) dw_q[u].push_back('{cyc, m_dcnt, 0, int'(b)});
        m_dcnt++;
      end
    end else begin
      m_seen = 1'b1;
      if (m_wcnt == 54) m_err = 1'b1;
      else begin
        for (int u = 0; u < 2; u++) ww_q[u].push_back('{cyc, m_wcnt, 0, int'(b)});
        m_wcnt++;
      end
    end
  endtask

  task automatic do_load(input int nd1, input int nw1, input int nd2, input int nw2);
    int i;
    bit ok;
    m_dcnt = 0;
    m_wcnt = 0;
    m_seen = 1'b0;
    m_err  = 1'b0;
    repeat (nd1) applyStimulus(1'b0, 8'($urandom));
    repeat (nw1) applyStimulus(1'b1, 8'($urandom));
    repeat (nd2) applyStimulus(1'b0, 8'($urandom));
    repeat (nw2) applyStimulus(1'b1, 8'($urandom));
    @(posedge clk);
    #1;
    ram_en = 1'b0;
    mode   = 1'($urandom);
    din    = 8'($urandom);
    last_l = cyc;
    ok = (m_dcnt == 64) && (m_wcnt == 54);
    if (ok) begin
      i = 0;
      for (int k = 0; k < 6; k++)
        for (int oy = 0; oy < 6; oy++)
          for (int ox = 0; ox < 6; ox++)
            for (int ky = 0; ky < 3; ky++)
              for (int kx = 0; kx < 3; kx++) begin
                for (int u = 0; u < 2; u++)
                  tap_q[u].push_back('{last_l + 1 + i + u + 1,
                                       (oy + ky) * 8 + ox + kx,
                                       k * 9 + ky * 3 + kx,
                                       ((ky == 0 && kx == 0) ? 1 : 0) + ((ky == 2 && kx == 2) ? 2 : 0)});
                i++;
              end
      for (int u = 0; u < 2; u++) done_q[u].push_back(last_l + 1944 + u + 1 + 1);
    end else begin
      m_err = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput("load_err after load", int'(err_o[u]), int'(m_err));
      checkOutput("busy after load", int'(busy_o[u]), int'(ok));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o != 2'b00 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("return to idle within budget", int'(n < 5000), 1);
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput("taps outstanding", tap_q[u].size(), 0);
      checkOutput("done outstanding", done_q[u].size(), 0);
      checkOutput("data writes outstanding", dw_q[u].size(), 0);
      checkOutput("weight writes outstanding", ww_q[u].size(), 0);
      tap_q[u].delete();
      done_q[u].delete();
      dw_q[u].delete();
      ww_q[u].delete();
    end
  endtask

  task automatic check_quiet(input string tag);
    for (int u = 0; u < 2; u++) begin
      checkOutput({tag, " busy"}, int'(busy_o[u]), 0);
      checkOutput({tag, " done"}, int'(done_o[u]), 0);
      checkOutput({tag, " load_err"}, int'(err_o[u]), 0);
      checkOutput({tag, " d_we"}, int'(d_we_o[u]), 0);
      checkOutput({tag, " w_we"}, int'(w_we_o[u]), 0);
      checkOutput({tag, " mac_en"}, int'(mac_en_o[u]), 0);
      checkOutput({tag, " d_addr"}, int'(d_addr_o[u]), 0);
      checkOutput({tag, " w_addr"}, int'(w_addr_o[u]), 0);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a write, a MAC tap or a done pulse.
  always @(negedge clk) begin : monitor
    ev_t e;
    for (int u = 0; u < 2; u++) begin
      hist_d[u][cyc % 4] = int'(d_addr_o[u]);
      hist_w[u][cyc % 4] = int'(w_addr_o[u]);
      if (d_we_o[u]) begin
        if (dw_q[u].size() == 0) checkOutput("unexpected d_we", int'(d_we_o[u]), 0);
        else begin
          e = dw_q[u].pop_front();
          checkOutput("d_we cycle", cyc, e.cyc);
          checkOutput("d_addr write", int'(d_addr_o[u]), e.a);
          checkOutput("d_wdata", int'(d_wdata_o[u]), e.f);
        end
      end
      if (w_we_o[u]) begin
        if (ww_q[u].size() == 0) checkOutput("unexpected w_we", int'(w_we_o[u]), 0);
        else begin
          e = ww_q[u].pop_front();
          checkOutput("w_we cycle", cyc, e.cyc);
          checkOutput("w_addr write", int'(w_addr_o[u]), e.a);
          checkOutput("w_wdata", int'(w_wdata_o[u]), e.f);
        end
      end
      if (mac_en_o[u]) begin
        if (tap_q[u].size() == 0) checkOutput("unexpected mac_en", int'(mac_en_o[u]), 0);
        else begin
          e = tap_q[u].pop_front();
          checkOutput("mac_en cycle", cyc, e.cyc);
          checkOutput("tap d_addr", hist_d[u][(cyc - u - 1) % 4], e.a);
          checkOutput("tap w_addr", hist_w[u][(cyc - u - 1) % 4], e.b);
          checkOutput("mac_clr", int'(mac_clr_o[u]), e.f & 1);
          checkOutput("mac_last", int'(mac_last_o[u]), (e.f >> 1) & 1);
          n_clr[u]  += int'(mac_clr_o[u]);
          n_last[u] += int'(mac_last_o[u]);
        end
      end else begin
        checkOutput("mac flag without mac_en", int'(mac_clr_o[u] | mac_last_o[u]), 0);
      end
      if (done_o[u]) begin
        if (done_q[u].size() == 0) checkOutput("unexpected done", int'(done_o[u]), 0);
        else checkOutput("done cycle", cyc, done_q[u].pop_front());
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int nd, nw;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] nominal load and compute");
    for (int u = 0; u < 2; u++) begin
      n_clr[u]  = 0;
      n_last[u] = 0;
    end
    do_load(64, 54, 0, 0);
    wait_idle();
    for (int u = 0; u < 2; u++) begin
      checkOutput("mac_clr pulse count", n_clr[u], 216);
      checkOutput("mac_last pulse count", n_last[u], 216);
    end

    $display("[TB] short load");
    do_load(60, 0, 0, 0);
    wait_idle();

    $display("[TB] data overflow");
    do_load(70, 54, 0, 0);
    wait_idle();

    $display("[TB] data byte after weights");
    do_load(64, 20, 1, 34);
    wait_idle();

    $display("[TB] randomized loads");
    for (int r = 0; r < 3; r++) begin
      nd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(58, 68)) : 64;
      nw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(50, 57)) : 54;
      do_load(nd, nw, 0, 0);
      wait_idle();
    end

    $display("[TB] reset during compute");
    do_load(64, 54, 0, 0);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < last_l + 500);
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      while (tap_q[u].size() > 0 && tap_q[u][$].cyc > cyc) void'(tap_q[u].pop_back());
      done_q[u].delete();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("after mid-compute reset");
    wait_idle();

    $display("[TB] full reload after reset");
    do_load(64, 54, 0, 0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
